// File: rtl/iic_mon_pkg.sv
// Shared types and constants for the SCCB/I2C bus monitor.
//   REC_W          : record width, {kind[1:0], ack, byte[7:0]}
//   KIND_*         : record kind codes
//   state_t        : decoder FSM state encoding
//   rec_t          : packed record payload stored in the FIFO
package iic_mon_pkg;

   localparam int unsigned REC_W = 11;

   localparam logic [1:0] KIND_DATA   = 2'b00;
   localparam logic [1:0] KIND_START  = 2'b01;
   localparam logic [1:0] KIND_RSTART = 2'b10;
   localparam logic [1:0] KIND_STOP   = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      BITS = 1'b1
   } state_t;

   typedef struct packed {
      logic [1:0] kind;
      logic       ack;
      logic [7:0] data;
   } rec_t;

endpackage

// File: rtl/iic_line_filter.sv
// Synchroniser plus stability filter for one bus line.
//   ILA_clk, rstn : clock, async active-low reset
//   i_line        : raw pad value
//   o_filt        : filtered value; follows i_line only after FILT_CYCLES
//                   consecutive synchronised cycles of disagreement
module iic_line_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 4
) (
   input  logic ILA_clk,
   input  logic rstn,
   input  logic i_line,
   output logic o_filt
);

   localparam int unsigned CNT_W = $clog2(FILT_CYCLES + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_filt;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign o_filt   = r_filt;

   // The counter tops out at FILT_CYCLES-1: the edge that would take it to
   // FILT_CYCLES is the edge on which the filtered value flips.
   always_ff @(posedge ILA_clk or negedge rstn) begin
      if (!rstn) begin
         r_sync <= '1;
         r_cnt  <= '0;
         r_filt <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
         if (w_synced != r_filt) begin
            if (r_cnt == CNT_W'(FILT_CYCLES - 1)) begin
               r_filt <= w_synced;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/iic_bus_monitor.sv
// Passive SCCB/I2C bus decoder: filters SCL/SDA, decodes START, repeated
// START, STOP and data bytes with their ACK bit, and queues one record per
// event in a show-ahead FIFO drained over valid/ready.
//   ILA_clk, rstn          : clock, async active-low reset
//   scl_in, sda_in         : raw pad values
//   enable                 : 0 holds the decoder idle and suppresses records
//   rec_valid/ready/data   : head record handshake, data = {kind, ack, byte}
//   fifo_level             : entries held
//   overflow, clr_overflow : sticky drop flag and its clear
//   bus_busy               : high between START and STOP
module iic_bus_monitor
   import iic_mon_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CYCLES = 4,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                          ILA_clk,
   input  logic                          rstn,
   input  logic                          scl_in,
   input  logic                          sda_in,
   input  logic                          enable,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [REC_W-1:0]              rec_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic                          bus_busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   logic w_f_scl, w_f_sda;
   logic r_p_scl, r_p_sda;
   logic w_start, w_stop, w_rise;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic       w_push;
   rec_t       w_push_rec;
   logic       r_push;
   rec_t       r_push_rec;

   rec_t          r_mem [FIFO_DEPTH];
   logic [LW-1:0] r_wr, r_rd;
   logic          r_ovf;
   logic          w_full, w_pop, w_wr_ok;

   iic_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_scl_filt (
      .ILA_clk (ILA_clk),
      .rstn    (rstn),
      .i_line  (scl_in),
      .o_filt  (w_f_scl)
   );

   iic_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sda_filt (
      .ILA_clk (ILA_clk),
      .rstn    (rstn),
      .i_line  (sda_in),
      .o_filt  (w_f_sda)
   );

   // Requiring SCL high on both samples keeps simultaneous SCL/SDA flips
   // from being read as START or STOP.
   assign w_start = r_p_scl & w_f_scl & r_p_sda & ~w_f_sda;
   assign w_stop  = r_p_scl & w_f_scl & ~r_p_sda & w_f_sda;
   assign w_rise  = ~r_p_scl & w_f_scl;

   // Decoder state and registered push request
   always_ff @(posedge ILA_clk or negedge rstn) begin
      if (!rstn) begin
         r_p_scl    <= 1'b1;
         r_p_sda    <= 1'b1;
         r_state    <= IDLE;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_push     <= 1'b0;
         r_push_rec <= '0;
      end else begin
         r_p_scl    <= w_f_scl;
         r_p_sda    <= w_f_sda;
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_push     <= w_push;
         r_push_rec <= w_push_rec;
      end
   end

   // Next state and record generation
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_push        = 1'b0;
      w_push_rec    = '0;
      if (!enable) begin
         w_state_nxt   = IDLE;
         w_bit_cnt_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  w_push          = 1'b1;
                  w_push_rec.kind = KIND_START;
                  w_state_nxt     = BITS;
                  w_bit_cnt_nxt   = '0;
               end
            end
            BITS: begin
               if (w_start) begin
                  w_push          = 1'b1;
                  w_push_rec.kind = KIND_RSTART;
                  w_bit_cnt_nxt   = '0;
               end else if (w_stop) begin
                  w_push          = 1'b1;
                  w_push_rec.kind = KIND_STOP;
                  w_state_nxt     = IDLE;
                  w_bit_cnt_nxt   = '0;
               end else if (w_rise) begin
                  if (r_bit_cnt == 4'd8) begin
                     // Ninth clock carries the ACK bit and closes the byte
                     w_push          = 1'b1;
                     w_push_rec.kind = KIND_DATA;
                     w_push_rec.ack  = w_f_sda;
                     w_push_rec.data = r_shift;
                     w_bit_cnt_nxt   = '0;
                  end else begin
                     w_shift_nxt   = {r_shift[6:0], w_f_sda};
                     w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign fifo_level = r_wr - r_rd;
   assign w_full     = (fifo_level == LW'(FIFO_DEPTH));
   assign rec_valid  = (fifo_level != '0);
   assign w_pop      = rec_valid & rec_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign w_wr_ok    = r_push & (~w_full | w_pop);
   assign rec_data   = r_mem[r_rd[AW-1:0]];
   assign overflow   = r_ovf;
   assign bus_busy   = (r_state == BITS);

   // Record storage
   always_ff @(posedge ILA_clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr[AW-1:0]] <= r_push_rec;
      end
   end

   // Pointers and sticky overflow; a drop in the same cycle beats the clear
   always_ff @(posedge ILA_clk or negedge rstn) begin
      if (!rstn) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_wr_ok) begin
            r_wr <= r_wr + LW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + LW'(1);
         end
         if (r_push && !w_wr_ok) begin
            r_ovf <= 1'b1;
         end else if (clr_overflow) begin
            r_ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iic_bus_monitor.sv
// Directed bench for iic_bus_monitor (FIFO_DEPTH = 4, other parameters default).
module tb_iic_bus_monitor;

   localparam int H = 8;

   logic        ILA_clk;
   logic        rstn;
   logic        scl_in;
   logic        sda_in;
   logic        enable;
   logic        rec_valid;
   logic        rec_ready;
   logic [10:0] rec_data;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        clr_overflow;
   logic        bus_busy;

   int n_pass  = 0;
   int n_total = 0;
   logic [10:0] q[$];

   iic_bus_monitor #(.SYNC_STAGES(2), .FILT_CYCLES(4), .FIFO_DEPTH(4)) dut (
      .ILA_clk      (ILA_clk),
      .rstn         (rstn),
      .scl_in       (scl_in),
      .sda_in       (sda_in),
      .enable       (enable),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready),
      .rec_data     (rec_data),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .bus_busy     (bus_busy)
   );

   initial ILA_clk = 1'b0;
   always #5 ILA_clk = ~ILA_clk;

   // Capture every record the consumer takes; the pop lands on the next rising edge
   always @(negedge ILA_clk) begin
      if (rstn && rec_valid && rec_ready) q.push_back(rec_data);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge ILA_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic expect_rec(input string tag, input logic [10:0] exp);
      logic [10:0] got;
      if (q.size() > 0) got = q.pop_front();
      else got = 'x;
      chk(tag, 32'(got), 32'(exp));
   endtask

   task automatic bus_start();
      sda_in = 1'b1; tick(H);
      scl_in = 1'b1; tick(H);
      sda_in = 1'b0; tick(H);
      scl_in = 1'b0; tick(H);
   endtask

   task automatic bus_stop();
      sda_in = 1'b0; tick(H);
      scl_in = 1'b1; tick(H);
      sda_in = 1'b1; tick(H);
   endtask

   task automatic send_bit(input logic b);
      sda_in = b;    tick(H);
      scl_in = 1'b1; tick(H);
      scl_in = 1'b0; tick(H);
   endtask

   // Bit whose SCL high phase contains a low glitch of n cycles
   task automatic glitch_bit(input logic b, input int n);
      sda_in = b;    tick(H);
      scl_in = 1'b1; tick(H);
      scl_in = 1'b0; tick(n);
      scl_in = 1'b1; tick(H);
      scl_in = 1'b0; tick(H);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      send_bit(ack);
   endtask

   initial begin
      rstn = 1'b0; scl_in = 1'b1; sda_in = 1'b1; enable = 1'b1;
      rec_ready = 1'b0; clr_overflow = 1'b0;
      tick(3);
      chk("rst_valid", 32'(rec_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(bus_busy), 32'd0);
      rstn = 1'b1;
      tick(H);

      // Write 0x78 / 0x0A with START latency measured from the SDA pin edge
      rec_ready = 1'b1;
      sda_in = 1'b0;
      tick(7);
      chk("lat_7", 32'(rec_valid), 32'd0);
      tick(1);
      chk("lat_8", 32'(rec_valid), 32'd1);
      chk("busy_on", 32'(bus_busy), 32'd1);
      tick(H);
      scl_in = 1'b0; tick(H);
      send_byte(8'h78, 1'b0);
      send_byte(8'h0A, 1'b0);
      chk("busy_mid", 32'(bus_busy), 32'd1);
      bus_stop();
      tick(2*H);
      chk("busy_off", 32'(bus_busy), 32'd0);
      expect_rec("wr_start", 11'h200);
      expect_rec("wr_addr", 11'h078);
      expect_rec("wr_reg", 11'h00A);
      expect_rec("wr_stop", 11'h600);
      chk("wr_empty", 32'(q.size()), 32'd0);

      // Read byte with NACK
      bus_start();
      send_byte(8'hFF, 1'b1);
      bus_stop();
      tick(2*H);
      expect_rec("rd_start", 11'h200);
      expect_rec("rd_nack", 11'h1FF);
      expect_rec("rd_stop", 11'h600);

      // Short SCL glitch while idle
      scl_in = 1'b0; tick(3);
      scl_in = 1'b1; tick(2*H);
      chk("glitch_idle_q", 32'(q.size()), 32'd0);
      chk("glitch_idle_valid", 32'(rec_valid), 32'd0);

      // Short glitch mid-byte is ignored; a FILT_CYCLES glitch adds a clock
      bus_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      glitch_bit(1'b0, 3);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      glitch_bit(1'b0, 4);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b0);
      bus_stop();
      tick(2*H);
      expect_rec("gl_start", 11'h200);
      expect_rec("gl_short", 11'h0A5);
      expect_rec("gl_long", 11'h0A6);
      expect_rec("gl_stop", 11'h600);

      // Repeated START after 3 bits drops the partial byte
      bus_start();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      bus_start();
      send_byte(8'h79, 1'b0);
      bus_stop();
      tick(2*H);
      expect_rec("rs_start", 11'h200);
      expect_rec("rs_rstart", 11'h400);
      expect_rec("rs_byte", 11'h079);
      expect_rec("rs_stop", 11'h600);
      chk("rs_empty", 32'(q.size()), 32'd0);

      // Overflow with consumer stalled: six events into four entries
      rec_ready = 1'b0;
      bus_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      bus_start();
      send_byte(8'h33, 1'b0);
      bus_stop();
      tick(2*H);
      chk("ovf_level", 32'(fifo_level), 32'd4);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_valid", 32'(rec_valid), 32'd1);
      chk("ovf_head", 32'(rec_data), 32'h200);
      clr_overflow = 1'b1; tick(1);
      clr_overflow = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);

      // Full FIFO: push and pop on the same edge (8 cycles after the SDA fall)
      sda_in = 1'b0;
      tick(7);
      rec_ready = 1'b1;
      tick(1);
      rec_ready = 1'b0;
      chk("pp_level", 32'(fifo_level), 32'd4);
      chk("pp_ovf", 32'(overflow), 32'd0);
      rec_ready = 1'b1;
      tick(2*H);
      scl_in = 1'b0; tick(H);
      bus_stop();
      tick(2*H);
      expect_rec("pp_r0", 11'h200);
      expect_rec("pp_r1", 11'h011);
      expect_rec("pp_r2", 11'h022);
      expect_rec("pp_r3", 11'h400);
      expect_rec("pp_r4", 11'h200);
      expect_rec("pp_r5", 11'h600);
      chk("pp_drained", 32'(fifo_level), 32'd0);

      // Reset mid-byte, then STOP and bits without START
      bus_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      tick(2*H);
      q.delete();
      rstn = 1'b0; tick(2);
      rstn = 1'b1; tick(H);
      chk("rst_mid_busy", 32'(bus_busy), 32'd0);
      bus_stop();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      tick(2*H);
      chk("rst_mid_q", 32'(q.size()), 32'd0);
      chk("rst_mid_valid", 32'(rec_valid), 32'd0);
      bus_start();
      send_byte(8'h5A, 1'b0);
      bus_stop();
      tick(2*H);
      expect_rec("post_rst_start", 11'h200);
      expect_rec("post_rst_byte", 11'h05A);
      expect_rec("post_rst_stop", 11'h600);

      // Decoder disabled for a whole transaction
      enable = 1'b0;
      bus_start();
      chk("dis_busy", 32'(bus_busy), 32'd0);
      send_byte(8'h42, 1'b0);
      bus_stop();
      tick(2*H);
      chk("dis_q", 32'(q.size()), 32'd0);
      chk("dis_valid", 32'(rec_valid), 32'd0);
      enable = 1'b1;
      tick(H);
      chk("end_ovf", 32'(overflow), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
